thor2024_cache_tag_ctrl: RTL and testbench

THOR2024_CACHE_TAG_CTRL -- requirements
Module: Thor2024_cache_tag_ctrl

---
 rtl/thor2024_cache_pkg.sv | 14 +
 rtl/thor2024_pkg.sv | 8 +
 rtl/thor2024_cache_rr_way.sv | 53 +++++
 rtl/thor2024_cache_tag_ctrl.sv | 167 ++++++++++++++++
 tb/tb_thor2024_cache_tag_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/thor2024_cache_pkg.sv
// Cache-subsystem shared types: tag controller state and way index.
package thor2024_cache_pkg;

    localparam int unsigned WAY_W = 2;

    typedef logic [WAY_W-1:0] way_t;

    typedef enum logic [1:0] {
        TC_SWEEP = 2'd0,
        TC_IDLE  = 2'd1,
        TC_FILL  = 2'd2
    } tag_ctrl_state_t;

endpackage : thor2024_cache_pkg

// File: rtl/thor2024_pkg.sv
// Core-wide shared types for the Thor2024 processor.
package thor2024_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef logic [ADDR_W-1:0] address_t;

endpackage : thor2024_pkg

// File: rtl/thor2024_cache_rr_way.sv
// Per-line round-robin replacement pointers: one 2-bit way pointer per line,
// with a clear port (used by the invalidate sweep), an increment port (used
// by fills) and an asynchronous read port.
module thor2024_cache_rr_way
    import thor2024_cache_pkg::*;
#(
    parameter int unsigned LINES = 64,
    parameter int unsigned WAYS  = 4,
    parameter int unsigned IW    = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [IW-1:0]     clr_idx,
    input  logic              inc,
    input  logic [IW-1:0]     inc_idx,
    input  logic [IW-1:0]     rd_idx,
    output logic [WAY_W-1:0]  rd_way_c
);

    way_t ptr_q [LINES];
    way_t ptr_d [LINES];

    // Pointer table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    // Clear the swept line and advance the filled line's pointer (wraps at WAYS).
    always_comb begin
        for (int i = 0; i < LINES; i++) begin
            ptr_d[i] = ptr_q[i];
        end
        if (clr) begin
            ptr_d[clr_idx] = '0;
        end
        if (inc) begin
            ptr_d[inc_idx] = (ptr_q[inc_idx] == way_t'(WAYS - 1)) ? '0
                                                                 : ptr_q[inc_idx] + way_t'(1);
        end
    end

    assign rd_way_c = ptr_q[rd_idx];

endmodule : thor2024_cache_rr_way

// File: rtl/thor2024_cache_tag_ctrl.sv
// Tag-array controller: invalidates every line after reset or on flush,
// then serves one tag fill per two cycles using per-line round-robin ways.
module thor2024_cache_tag_ctrl
    import thor2024_pkg::*;
    import thor2024_cache_pkg::*;
#(
    parameter int unsigned LINES = 64,
    parameter int unsigned WAYS  = 4,
    parameter int unsigned LOBIT = 6,
    parameter int unsigned HIBIT = $clog2(LINES) - 1 + LOBIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_req,
    input  logic        fill_req,
    input  address_t    fill_vadr,
    input  address_t    fill_padr,
    output logic        fill_ack,
    output logic [1:0]  fill_way,
    output logic        tag_rst,
    output logic        tag_wr,
    output address_t    tag_vadr,
    output address_t    tag_padr,
    output logic [1:0]  tag_way,
    output logic        ready,
    output logic        sweep_done
);

    localparam int unsigned IW = HIBIT - LOBIT + 1;

    tag_ctrl_state_t state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;

    logic       fill_ack_q,   fill_ack_d;
    way_t       fill_way_q,   fill_way_d;
    logic       tag_rst_q,    tag_rst_d;
    logic       tag_wr_q,     tag_wr_d;
    address_t   tag_vadr_q,   tag_vadr_d;
    address_t   tag_padr_q,   tag_padr_d;
    way_t       tag_way_q,    tag_way_d;
    logic       ready_q,      ready_d;
    logic       sweep_done_q, sweep_done_d;

    logic       rr_clr;
    logic       rr_inc;
    logic [IW-1:0] fill_idx;
    way_t       rr_way_c;

    assign fill_idx = fill_vadr[HIBIT:LOBIT];
    assign rr_clr   = (state_q == TC_SWEEP);
    assign rr_inc   = (state_q == TC_IDLE) && (state_d == TC_FILL);

    thor2024_cache_rr_way #(
        .LINES (LINES),
        .WAYS  (WAYS),
        .IW    (IW)
    ) u_rr_way (
        .clk      (clk),
        .rst      (rst),
        .clr      (rr_clr),
        .clr_idx  (cnt_q),
        .inc      (rr_inc),
        .inc_idx  (fill_idx),
        .rd_idx   (fill_idx),
        .rd_way_c (rr_way_c)
    );

    // State, sweep counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= TC_SWEEP;
            cnt_q        <= '0;
            fill_ack_q   <= 1'b0;
            fill_way_q   <= '0;
            tag_rst_q    <= 1'b1;
            tag_wr_q     <= 1'b0;
            tag_vadr_q   <= '0;
            tag_padr_q   <= '0;
            tag_way_q    <= '0;
            ready_q      <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_ack_q   <= fill_ack_d;
            fill_way_q   <= fill_way_d;
            tag_rst_q    <= tag_rst_d;
            tag_wr_q     <= tag_wr_d;
            tag_vadr_q   <= tag_vadr_d;
            tag_padr_q   <= tag_padr_d;
            tag_way_q    <= tag_way_d;
            ready_q      <= ready_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Next state: sweep runs LINES cycles; flush outranks fill in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            TC_SWEEP: begin
                if (cnt_q == IW'(LINES - 1)) begin
                    state_d = TC_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            TC_IDLE: begin
                if (flush_req) begin
                    state_d = TC_SWEEP;
                    cnt_d   = '0;
                end else if (fill_req) begin
                    state_d = TC_FILL;
                end
            end
            TC_FILL: begin
                state_d = TC_IDLE;
            end
            default: begin
                state_d = TC_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the upcoming state, registered on the next edge.
    always_comb begin
        fill_ack_d   = 1'b0;
        fill_way_d   = '0;
        tag_rst_d    = 1'b0;
        tag_wr_d     = 1'b0;
        tag_vadr_d   = '0;
        tag_padr_d   = '0;
        tag_way_d    = '0;
        ready_d      = (state_d == TC_IDLE);
        sweep_done_d = (state_q == TC_SWEEP) && (state_d == TC_IDLE);
        unique case (state_d)
            TC_SWEEP: begin
                tag_rst_d               = 1'b1;
                tag_vadr_d[HIBIT:LOBIT] = cnt_d;
            end
            TC_FILL: begin
                tag_wr_d   = 1'b1;
                fill_ack_d = 1'b1;
                tag_vadr_d = fill_vadr;
                tag_padr_d = fill_padr;
                tag_way_d  = rr_way_c;
                fill_way_d = rr_way_c;
            end
            default: begin
            end
        endcase
    end

    assign fill_ack   = fill_ack_q;
    assign fill_way   = fill_way_q;
    assign tag_rst    = tag_rst_q;
    assign tag_wr     = tag_wr_q;
    assign tag_vadr   = tag_vadr_q;
    assign tag_padr   = tag_padr_q;
    assign tag_way    = tag_way_q;
    assign ready      = ready_q;
    assign sweep_done = sweep_done_q;

endmodule : thor2024_cache_tag_ctrl

// File: tb/tb_thor2024_cache_tag_ctrl.sv
// Self-checking bench for the tag controller: sweeps, fills, flush and
// reset interruptions, checked against a per-line round-robin model.
module tb_thor2024_cache_tag_ctrl;

    localparam int LINES = 64;
    localparam int LOBIT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        fill_req;
    logic [31:0] fill_vadr;
    logic [31:0] fill_padr;
    logic        fill_ack;
    logic [1:0]  fill_way;
    logic        tag_rst;
    logic        tag_wr;
    logic [31:0] tag_vadr;
    logic [31:0] tag_padr;
    logic [1:0]  tag_way;
    logic        ready;
    logic        sweep_done;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: next way to use for each line.
    int model_ptr [LINES];

    thor2024_cache_tag_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush_req  (flush_req),
        .fill_req   (fill_req),
        .fill_vadr  (fill_vadr),
        .fill_padr  (fill_padr),
        .fill_ack   (fill_ack),
        .fill_way   (fill_way),
        .tag_rst    (tag_rst),
        .tag_wr     (tag_wr),
        .tag_vadr   (tag_vadr),
        .tag_padr   (tag_padr),
        .tag_way    (tag_way),
        .ready      (ready),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) model_ptr[i] = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tag_rst"},    64'(tag_rst),    64'd1);
        chk({tag, "_tag_wr"},     64'(tag_wr),     64'd0);
        chk({tag, "_fill_ack"},   64'(fill_ack),   64'd0);
        chk({tag, "_sweep_done"}, 64'(sweep_done), 64'd0);
        chk({tag, "_ready"},      64'(ready),      64'd0);
        chk({tag, "_tag_vadr"},   64'(tag_vadr),   64'd0);
        chk({tag, "_tag_padr"},   64'(tag_padr),   64'd0);
        chk({tag, "_tag_way"},    64'(tag_way),    64'd0);
        chk({tag, "_fill_way"},   64'(fill_way),   64'd0);
    endtask

    // Expects the current sample to show sweep index 0; pulses flush_req
    // mid-sweep when flush_at is a valid index.
    task automatic sweep_check(input int flush_at);
        for (int i = 0; i < LINES; i++) begin
            chk("sweep_tag_rst",  64'(tag_rst),  64'd1);
            chk("sweep_index",    64'(tag_vadr), 64'(i) << LOBIT);
            chk("sweep_tag_wr",   64'(tag_wr),   64'd0);
            chk("sweep_fill_ack", 64'(fill_ack), 64'd0);
            chk("sweep_ready",    64'(ready),    64'd0);
            chk("sweep_done_early", 64'(sweep_done), 64'd0);
            if (i == flush_at)     flush_req = 1'b1;
            if (i == flush_at + 3) flush_req = 1'b0;
            tick();
        end
        chk("sweep_done_pulse", 64'(sweep_done), 64'd1);
        chk("sweep_end_ready",  64'(ready),      64'd1);
        chk("sweep_end_tag_rst", 64'(tag_rst),   64'd0);
        model_clear();
    endtask

    // One fill from IDLE: ack on the next cycle, then back to IDLE.
    task automatic do_fill(input logic [31:0] va, input logic [31:0] pa);
        int idx;
        int exp_way;
        idx     = int'((va >> LOBIT) % LINES);
        exp_way = model_ptr[idx];
        model_ptr[idx] = (exp_way + 1) % 4;
        fill_req  = 1'b1;
        fill_vadr = va;
        fill_padr = pa;
        tick();
        chk("fill_ack",      64'(fill_ack), 64'd1);
        chk("fill_tag_wr",   64'(tag_wr),   64'd1);
        chk("fill_way",      64'(fill_way), 64'(exp_way));
        chk("fill_tag_way",  64'(tag_way),  64'(exp_way));
        chk("fill_tag_vadr", 64'(tag_vadr), 64'(va));
        chk("fill_tag_padr", 64'(tag_padr), 64'(pa));
        chk("fill_ready",    64'(ready),    64'd0);
        fill_req = 1'b0;
        tick();
        chk("post_fill_ack",   64'(fill_ack), 64'd0);
        chk("post_fill_wr",    64'(tag_wr),   64'd0);
        chk("post_fill_ready", 64'(ready),    64'd1);
    endtask

    function automatic logic [31:0] rand_vadr();
        logic [31:0] v;
        v = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << LOBIT) | ($urandom & 32'h3F);
        return v;
    endfunction

    initial begin
        logic [31:0] va;
        int idx;
        int exp_way;

        rst = 1'b1; flush_req = 1'b0; fill_req = 1'b0;
        fill_vadr = '0; fill_padr = '0;
        model_clear();

        // Reset state, then automatic sweep after release.
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        sweep_check(-100);

        // Same line filled five times: ways 0,1,2,3 then wrap to 0.
        for (int k = 0; k < 5; k++) begin
            do_fill(32'h0000_1040, $urandom);
        end

        // Flush and fill together: flush wins, fill waits for the sweep.
        fill_req  = 1'b1;
        fill_vadr = 32'h0000_1040;
        fill_padr = 32'hCAFE_0000;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        sweep_check(30);
        chk("flush_fill_no_early_ack", 64'(fill_ack), 64'd0);
        tick();
        chk("flush_fill_ack", 64'(fill_ack), 64'd1);
        chk("flush_fill_way", 64'(fill_way), 64'd0);
        model_ptr[(32'h1040 >> LOBIT) % LINES] = 1;
        fill_req = 1'b0;
        tick();
        chk("flush_fill_idle", 64'(ready), 64'd1);

        // Fresh sweep, then alternating lines keep independent pointers.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        sweep_check(-100);
        for (int k = 0; k < 6; k++) begin
            do_fill((k % 2 == 0) ? 32'h0000_0040 : 32'h0000_0080, $urandom);
        end

        // Held fill_req: one ack every other cycle.
        va = rand_vadr();
        fill_req  = 1'b1;
        fill_vadr = va;
        fill_padr = $urandom;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k % 2 == 0) begin
                idx     = int'((va >> LOBIT) % LINES);
                exp_way = model_ptr[idx];
                model_ptr[idx] = (exp_way + 1) % 4;
                chk("thru_ack", 64'(fill_ack), 64'd1);
                chk("thru_way", 64'(fill_way), 64'(exp_way));
                va = rand_vadr();
                fill_vadr = va;
                fill_padr = $urandom;
            end else begin
                chk("thru_gap_ack", 64'(fill_ack), 64'd0);
                chk("thru_gap_wr",  64'(tag_wr),   64'd0);
                chk("thru_gap_ready", 64'(ready),  64'd1);
            end
        end
        fill_req = 1'b0;
        tick();
        chk("thru_end_ack", 64'(fill_ack), 64'd0);

        // Randomized fills across a few lines.
        for (int k = 0; k < 30; k++) begin
            do_fill(rand_vadr(), $urandom);
        end

        // Reset at sweep index 20.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (20) tick();
        chk("mid_sweep_index", 64'(tag_vadr), 64'd20 << LOBIT);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid_sweep");
        tick();
        rst = 1'b0;
        sweep_check(-100);

        // Reset during a FILL cycle.
        do_fill(32'h0000_1040, 32'h1234_5678);
        fill_req  = 1'b1;
        fill_vadr = 32'h0000_1040;
        fill_padr = 32'h8765_4321;
        tick();
        chk("pre_rst_fill_ack", 64'(fill_ack), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid_fill");
        fill_req = 1'b0;
        tick();
        rst = 1'b0;
        sweep_check(-100);
        do_fill(32'h0000_1040, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_thor2024_cache_tag_ctrl
